// File: rtl/inst_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_pkg
//   Shared definitions for the instruction fetch front end:
//   - RV32 opcode constants used by static next-PC prediction
//   - default reset PC
//   - instruction-queue entry layout {inst, pc, pred_taken}
// -----------------------------------------------------------------------------
package inst_fetch_unit_pkg;

    localparam logic [6:0]  OPC_JAL          = 7'b1101111;
    localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred_taken;
    } iq_entry_t;

endpackage

// File: rtl/inst_fetch_unit_predecode.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_predecode
//   Purely combinational static predictor for one fetched instruction.
//   Kept standalone so a later BTB stage can reuse it unchanged.
//
//   Ports:
//     inst        in  32  fetched instruction
//     pc          in  32  address of inst
//     pred_taken  out  1  JAL, or conditional branch with a backward offset
//     next_pc     out 32  predicted address of the following fetch
// -----------------------------------------------------------------------------
module inst_fetch_unit_predecode
    import inst_fetch_unit_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    output logic        pred_taken,
    output logic [31:0] next_pc
);

    logic [31:0] j_imm;
    logic [31:0] b_imm;

    always_comb begin
        j_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        b_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};

        pred_taken = 1'b0;
        next_pc    = pc + 32'd4;

        if (inst[6:0] == OPC_JAL) begin
            pred_taken = 1'b1;
            next_pc    = pc + j_imm;
        end else if ((inst[6:0] == OPC_BRANCH) && inst[31]) begin
            // Backward-taken / forward-not-taken: inst[31] is the B-imm sign.
            pred_taken = 1'b1;
            next_pc    = pc + b_imm;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//   Front-end stage upstream of the instruction cache. Owns the PC, presents
//   the next fetch address to the icache, matches the icache's one-cycle
//   registered response against the outstanding request, predicts the next
//   PC and buffers fetched instructions in a circular queue for decode.
//
//   Ports:
//     clk_in          in   1  clock
//     rst_in          in   1  asynchronous active-low reset
//     req_pc          out 32  fetch address, sampled by the icache at posedge
//     inst_in         in  32  instruction returned by the icache
//     inst_valid      in   1  inst_in valid (registered in the icache)
//     redirect_valid  in   1  flush + refetch request, highest priority
//     redirect_pc     in  32  new fetch address
//     iq_valid        out  1  queue head valid
//     iq_ready        in   1  decoder consumes the head
//     iq_inst         out 32  head instruction
//     iq_pc           out 32  head PC
//     iq_pred_taken   out  1  head predicted taken
// -----------------------------------------------------------------------------
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int          IQ_SIZE_LOG = 3,
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic [31:0] req_pc,
    input  logic [31:0] inst_in,
    input  logic        inst_valid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        iq_valid,
    input  logic        iq_ready,
    output logic [31:0] iq_inst,
    output logic [31:0] iq_pc,
    output logic        iq_pred_taken
);

    localparam int                     DEPTH     = 1 << IQ_SIZE_LOG;
    localparam logic [IQ_SIZE_LOG:0]   DEPTH_CNT = (IQ_SIZE_LOG + 1)'(DEPTH);
    localparam logic [IQ_SIZE_LOG:0]   CNT_ONE   = (IQ_SIZE_LOG + 1)'(1);
    localparam logic [IQ_SIZE_LOG-1:0] PTR_ONE   = IQ_SIZE_LOG'(1);

    logic [31:0]            fetch_pc_q, fetch_pc_d;
    logic                   req_seen_q, req_seen_d;
    logic [31:0]            last_req_q, last_req_d;
    logic [IQ_SIZE_LOG-1:0] head_q, head_d;
    logic [IQ_SIZE_LOG-1:0] tail_q, tail_d;
    logic [IQ_SIZE_LOG:0]   count_q, count_d;

    iq_entry_t iq_mem [DEPTH];
    iq_entry_t head_entry;

    logic        pd_taken;
    logic [31:0] pd_next_pc;
    logic        has_entry;
    logic        usable;
    logic        accept;
    logic        pop;
    logic [31:0] next_pc;

    inst_fetch_unit_predecode u_predecode (
        .inst       (inst_in),
        .pc         (fetch_pc_q),
        .pred_taken (pd_taken),
        .next_pc    (pd_next_pc)
    );

    always_comb begin
        has_entry = (count_q != '0);

        // The icache answers one cycle after sampling req_pc. A response only
        // belongs to fetch_pc if that same address was presented last cycle
        // and no redirect intervened.
        usable = req_seen_q && (last_req_q == fetch_pc_q) && inst_valid;

        // A full queue stalls even when the head is popped this cycle.
        accept = usable && (count_q < DEPTH_CNT) && !redirect_valid;

        // A pop coinciding with a redirect is dropped; the decoder flushes too.
        pop = has_entry && iq_ready && !redirect_valid;

        if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (accept) begin
            next_pc = pd_next_pc;
        end else begin
            next_pc = fetch_pc_q;
        end

        fetch_pc_d = next_pc;
        last_req_d = req_pc;
        req_seen_d = !redirect_valid;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect_valid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (accept) begin
                tail_d = tail_q + PTR_ONE;
            end
            if (pop) begin
                head_d = head_q + PTR_ONE;
            end
            case ({accept, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // While reset is held the icache must see the reset PC, even if a
    // redirect is being driven.
    assign req_pc = rst_in ? next_pc : RESET_PC;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            fetch_pc_q <= RESET_PC;
            req_seen_q <= 1'b0;
            last_req_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_seen_q <= req_seen_d;
            last_req_q <= last_req_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Queue storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            iq_mem[tail_q] <= '{inst: inst_in, pc: fetch_pc_q, pred_taken: pd_taken};
        end
    end

    // Head fields are forced to zero when the queue is empty so that reset
    // and flush present clean outputs regardless of stale storage.
    always_comb begin
        head_entry    = iq_mem[head_q];
        iq_valid      = has_entry;
        iq_inst       = '0;
        iq_pc         = '0;
        iq_pred_taken = 1'b0;
        if (has_entry) begin
            iq_inst       = head_entry.inst;
            iq_pc         = head_entry.pc;
            iq_pred_taken = head_entry.pred_taken;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
`timescale 1ns/1ps
module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] req_pc;
    logic [31:0] inst_in = 32'h0;
    logic        inst_valid = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        iq_valid;
    logic        iq_ready = 1'b1;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic        iq_pred_taken;

    always #5 clk_in = ~clk_in;

    inst_fetch_unit #(.IQ_SIZE_LOG(3), .RESET_PC(RESET_PC)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .req_pc         (req_pc),
        .inst_in        (inst_in),
        .inst_valid     (inst_valid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .iq_valid       (iq_valid),
        .iq_ready       (iq_ready),
        .iq_inst        (iq_inst),
        .iq_pc          (iq_pc),
        .iq_pred_taken  (iq_pred_taken)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        taken;
    } exp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        exp_q[$];
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] ovr [logic [31:0]];
    logic        miss_en = 1'b0;
    logic        miss_rand = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- program image ----------------
    function automatic logic [31:0] enc_jal(input int imm);
        logic [20:0] i;
        i = 21'(imm);
        return {i[20], i[10:1], i[11], i[19:12], 5'd0, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_br(input int imm, input logic [2:0] f3);
        logic [12:0] i;
        i = 13'(imm);
        return {i[12], i[10:5], 5'd2, 5'd1, f3, i[4:1], i[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        logic [31:0] h;
        logic [31:0] w;
        if (ovr.exists(pc)) return ovr[pc];
        h = (pc ^ 32'h5bd1_e995) * 32'h9e37_79b1;
        h = h ^ (h >> 13);
        case (h[3:0])
            4'd0, 4'd1: w = enc_jal(int'(h[9:4]) * 4 - 128);
            4'd2:       w = enc_br(-4 * (int'(h[8:4]) + 1), 3'd0);
            4'd3, 4'd4: w = enc_br(4 * (int'(h[8:4]) + 1), 3'd1);
            4'd5:       w = 32'h0000_8067;
            default:    w = {h[31:7], 7'b0010011};
        endcase
        return w;
    endfunction

    // Reference: the instruction stream the unit must deliver, derived from the
    // ISA rules (JAL taken, backward branch taken, everything else falls through).
    task automatic model_step(output exp_t e);
        logic [31:0] w;
        logic signed [31:0] off;
        w = mem_word(model_pc);
        e.inst  = w;
        e.pc    = model_pc;
        e.taken = 1'b0;
        off     = 32'sd4;
        if (w[6:0] == 7'b1101111) begin
            e.taken = 1'b1;
            off = $signed({{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0});
        end else if (w[6:0] == 7'b1100011 && w[31]) begin
            e.taken = 1'b1;
            off = $signed({{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0});
        end
        model_pc = model_pc + off;
    endtask

    task automatic topup();
        exp_t e;
        while (exp_q.size() < 16 && model_pc[31:16] == 16'h0) begin
            model_step(e);
            exp_q.push_back(e);
        end
    endtask

    // ---------------- icache model: 1-cycle registered, low 64 KiB only -------
    always @(posedge clk_in) begin
        if (!miss_en && !miss_rand && req_pc[31:16] == 16'h0) begin
            inst_valid <= 1'b1;
            inst_in    <= mem_word(req_pc);
        end else begin
            inst_valid <= 1'b0;
            inst_in    <= 32'hdead_beef;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk_in) begin
        exp_t e;
        if (rst_in && !redirect_valid && iq_valid && iq_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL iq_pop: got entry pc %h, expected no entry", iq_pc);
            end else begin
                e = exp_q.pop_front();
                if (iq_inst !== e.inst || iq_pc !== e.pc || iq_pred_taken !== e.taken) begin
                    n_bad++;
                    $display("FAIL iq_entry: got inst %h pc %h taken %0b, expected inst %h pc %h taken %0b",
                             iq_inst, iq_pc, iq_pred_taken, e.inst, e.pc, e.taken);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
        topup();
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        exp_q.delete();
        model_pc = pc;
        topup();
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic reset_pulse(input int cycles);
        rst_in = 1'b0;
        exp_q.delete();
        model_pc = RESET_PC;
        repeat (cycles) tick();
        rst_in = 1'b1;
    endtask

    task automatic check_next(input string name, input logic [31:0] start,
                              input logic [31:0] exp_next, input logic exp_taken);
        int n;
        n = 0;
        do_redirect(start);
        @(negedge clk_in);
        while (req_pc == start && n < 10) begin
            tick();
            @(negedge clk_in);
            n++;
        end
        check({name, "_req_pc"}, req_pc, exp_next);
        tick();
        @(negedge clk_in);
        check({name, "_head_pc"}, iq_pc, start);
        check({name, "_pred"}, 32'(iq_pred_taken), 32'(exp_taken));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] held;
        int n;

        ovr[32'h0] = NOP;
        ovr[32'h4] = NOP;
        ovr[32'h8] = NOP;
        for (int i = 0; i < 48; i++) ovr[32'h1000 + 32'(4 * i)] = NOP;

        // Reset state, including a redirect driven while in reset.
        repeat (3) tick();
        check("rst_iq_valid", 32'(iq_valid), 32'h0);
        check("rst_iq_inst", iq_inst, 32'h0);
        check("rst_iq_pc", iq_pc, 32'h0);
        check("rst_iq_pred", 32'(iq_pred_taken), 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1234;
        #1;
        check("rst_req_pc", req_pc, RESET_PC);
        redirect_valid = 1'b0;
        exp_q.delete();
        model_pc = RESET_PC;
        tick();
        rst_in = 1'b1;

        // NOP stream 0,4,8 on consecutive cycles.
        n = 0;
        @(negedge clk_in);
        while (!iq_valid && n < 10) begin
            tick();
            @(negedge clk_in);
            n++;
        end
        for (int k = 0; k < 3; k++) begin
            if (k != 0) begin
                tick();
                @(negedge clk_in);
            end
            check("seq_valid", 32'(iq_valid), 32'h1);
            check("seq_pc", iq_pc, 32'(4 * k));
            check("seq_pred", 32'(iq_pred_taken), 32'h0);
        end

        // Static prediction.
        tick();
        ovr[32'h20] = 32'h0100_006F;
        check_next("jal", 32'h20, 32'h30, 1'b1);
        tick();
        ovr[32'h40] = 32'hFE00_0CE3;
        check_next("beq_back", 32'h40, 32'h38, 1'b1);
        tick();
        ovr[32'h40] = 32'h0000_0463;
        check_next("beq_fwd", 32'h40, 32'h44, 1'b0);

        // Fill the queue, then confirm a full queue does not push on a pop.
        tick();
        iq_ready = 1'b0;
        do_redirect(32'h1000);
        repeat (13) tick();
        @(negedge clk_in);
        check("full_req_pc", req_pc, 32'h1020);
        check("full_head_pc", iq_pc, 32'h1000);
        tick();
        iq_ready = 1'b1;
        @(negedge clk_in);
        check("full_pop_stall", req_pc, 32'h1020);
        tick();
        @(negedge clk_in);
        check("full_resume", req_pc, 32'h1024);
        repeat (12) tick();

        // Redirect with five entries queued and a stale response in flight.
        iq_ready = 1'b0;
        do_redirect(32'h1000);
        repeat (6) tick();
        iq_ready = 1'b1;
        do_redirect(32'h100);
        @(negedge clk_in);
        check("redir_iq_valid", 32'(iq_valid), 32'h0);
        check("redir_req_pc", req_pc, 32'h100);

        // Cache miss for 20 cycles.
        tick();
        do_redirect(32'h1000);
        repeat (4) tick();
        miss_en = 1'b1;
        tick();
        @(negedge clk_in);
        held = req_pc;
        for (int k = 0; k < 20; k++) begin
            tick();
            @(negedge clk_in);
            check("miss_hold", req_pc, held);
        end
        tick();
        miss_en = 1'b0;
        repeat (6) tick();

        // Asynchronous reset with six entries queued.
        iq_ready = 1'b0;
        do_redirect(32'h1000);
        repeat (7) tick();
        check("pre_rst_valid", 32'(iq_valid), 32'h1);
        rst_in = 1'b0;
        exp_q.delete();
        model_pc = RESET_PC;
        #1;
        check("async_rst_valid", 32'(iq_valid), 32'h0);
        check("async_rst_pc", iq_pc, 32'h0);
        check("async_rst_req", req_pc, RESET_PC);
        tick();
        tick();
        rst_in   = 1'b1;
        iq_ready = 1'b1;
        #1;
        check("post_rst_req", req_pc, RESET_PC);

        // Out-of-range PC stalls until redirected.
        tick();
        do_redirect(32'h0001_0000);
        repeat (10) tick();
        @(negedge clk_in);
        check("oor_valid", 32'(iq_valid), 32'h0);
        check("oor_req_pc", req_pc, 32'h0001_0000);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            int r;
            tick();
            iq_ready  = ($urandom_range(0, 3) != 0);
            miss_rand = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 199);
            if (r < 4) begin
                do_redirect({16'h0, 14'($urandom_range(0, 16383)), 2'b00});
            end else if (r == 4) begin
                do_redirect({16'h0001 + 16'($urandom_range(0, 255)), 16'h0});
            end else if (r == 5) begin
                reset_pulse(2);
            end
        end
        miss_rand = 1'b0;
        iq_ready  = 1'b1;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
